// File: rtl/run_sequencer_if.sv
// Sequencer <-> top-level/datapath bundle: run handshake, fetch and branch info.
interface run_sequencer_if #(
    parameter int PC_W = 10
);
    logic            req;
    logic [2:0]      instr_op;
    logic            br_taken;
    logic [PC_W-1:0] br_target;
    logic [PC_W-1:0] pc;
    logic            init;
    logic            exec_en;
    logic            done;

    modport master (
        output req, instr_op, br_taken, br_target,
        input  pc, init, exec_en, done
    );

    modport slave (
        input  req, instr_op, br_taken, br_target,
        output pc, init, exec_en, done
    );
endinterface

// File: rtl/run_sequencer.sv
// Run-level sequencer: owns the PC, stretches LW, redirects on BRANCH.
// Optional cycle counter port under RUN_SEQ_CYCLE_COUNT_EN.
module run_sequencer #(
    parameter int PC_W     = 10,
    parameter int PROG_LEN = 1023,
    parameter int LW_WAIT  = 1
) (
    input  logic        clk,
    input  logic        reset,
    run_sequencer_if.slave bus
`ifdef RUN_SEQ_CYCLE_COUNT_EN
    ,
    output logic [31:0] cycle_cnt
`endif
);

    localparam logic [2:0]      OP_LW   = 3'b101;
    localparam logic [2:0]      OP_BR   = 3'b111;
    localparam logic [2:0]      WAIT_LD = 3'(LW_WAIT);
    localparam logic [PC_W-1:0] LAST_PC = PC_W'(PROG_LEN);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        LOAD_WAIT,
        DONE
    } state_t;

    state_t          state;
    logic [PC_W-1:0] pc_q;
    logic [2:0]      wait_cnt;

    logic            lw_stall;
    logic            take_br;
    logic            retire;
    logic [PC_W-1:0] pc_ret;
    state_t          st_ret;

    // Unknown opcodes fail both compares and fall through as plain ALU ops.
    always_comb begin
        lw_stall = 1'b0;
        take_br  = 1'b0;
        if (bus.instr_op == OP_LW && WAIT_LD != 3'd0)
            lw_stall = 1'b1;
        if (bus.instr_op == OP_BR && bus.br_taken)
            take_br = 1'b1;
    end

    always_comb begin
        retire = 1'b0;
        unique case (state)
            RUN:       retire = !lw_stall;
            LOAD_WAIT: retire = (wait_cnt == 3'd1);
            default:   retire = 1'b0;
        endcase
    end

    always_comb begin
        pc_ret = pc_q + PC_W'(1);
        st_ret = RUN;
        if (take_br) begin
            pc_ret = bus.br_target;
        end else if (pc_q == LAST_PC) begin
            pc_ret = pc_q;
            st_ret = DONE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            pc_q     <= '0;
            wait_cnt <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    pc_q <= '0;
                    if (bus.req)
                        state <= RUN;
                end
                RUN: begin
                    if (lw_stall) begin
                        wait_cnt <= WAIT_LD;
                        state    <= LOAD_WAIT;
                    end else begin
                        pc_q  <= pc_ret;
                        state <= st_ret;
                    end
                end
                LOAD_WAIT: begin
                    wait_cnt <= wait_cnt - 3'd1;
                    if (wait_cnt == 3'd1) begin
                        pc_q  <= pc_ret;
                        state <= st_ret;
                    end
                end
                DONE: begin
                    if (!bus.req) begin
                        pc_q  <= '0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // exec_en follows the opcode so a LW is held off in its first cycle.
    assign bus.pc      = pc_q;
    assign bus.exec_en = retire;
    assign bus.init    = (state == IDLE) || (state == DONE);
    assign bus.done    = (state == DONE);

`ifdef RUN_SEQ_CYCLE_COUNT_EN
    always_ff @(posedge clk) begin
        if (reset)
            cycle_cnt <= '0;
        else if (state == IDLE && bus.req)
            cycle_cnt <= '0;
        else if (state == RUN || state == LOAD_WAIT)
            cycle_cnt <= cycle_cnt + 32'd1;
    end
`endif

endmodule

// File: tb/tb_run_sequencer.sv
// Scoreboard bench for run_sequencer: PROG_LEN=3, LW_WAIT=2, directed program.
module tb_run_sequencer;

    localparam logic [2:0] ADD = 3'b000;
    localparam logic [2:0] LW  = 3'b101;
    localparam logic [2:0] BR  = 3'b111;

    typedef struct packed {
        logic [9:0]  pc;
        logic        ex;
        logic        init;
        logic        done;
        logic [31:0] cnt;
    } exp_t;

    logic clk;
    logic reset;
    logic bt;
    logic [9:0] tgt;
    logic [2:0] prog [4];
    logic [31:0] cnt_w;

    exp_t sb [$];
    int   n_vec;
    int   n_bad;

    run_sequencer_if #(.PC_W(10)) bus ();

    assign bus.instr_op  = prog[bus.pc[1:0]];
    assign bus.br_taken  = bt;
    assign bus.br_target = tgt;

    run_sequencer #(
        .PC_W(10),
        .PROG_LEN(3),
        .LW_WAIT(2)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
`ifdef RUN_SEQ_CYCLE_COUNT_EN
        ,
        .cycle_cnt(cnt_w)
`endif
    );

`ifndef RUN_SEQ_CYCLE_COUNT_EN
    assign cnt_w = '0;
`endif

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, queue=%0d", sb.size());
        $fatal(1, "watchdog");
    end

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            logic ok;
            e  = sb.pop_front();
            ok = (bus.pc == e.pc) && (bus.exec_en == e.ex) &&
                 (bus.init == e.init) && (bus.done == e.done);
`ifdef RUN_SEQ_CYCLE_COUNT_EN
            ok = ok && (cnt_w == e.cnt);
`endif
            n_vec++;
            if (!ok) begin
                n_bad++;
                $display("FAIL vec%0d t=%0t: got pc=%0d ex=%b init=%b done=%b cnt=%0d, want pc=%0d ex=%b init=%b done=%b cnt=%0d",
                         n_vec, $time, bus.pc, bus.exec_en, bus.init, bus.done, cnt_w,
                         e.pc, e.ex, e.init, e.done, e.cnt);
            end
        end
    end

    task automatic cyc(input logic r, input logic rs, input logic [9:0] p,
                       input logic e, input logic i, input logic d,
                       input logic [31:0] c);
        exp_t x;
        bus.req = r;
        reset   = rs;
        x.pc = p; x.ex = e; x.init = i; x.done = d; x.cnt = c;
        sb.push_back(x);
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;
        for (int k = 0; k < 4; k++) prog[k] = ADD;
        bt      = 1'b0;
        tgt     = '0;
        reset   = 1'b1;
        bus.req = 1'b0;
        @(posedge clk);
        #1;

        // reset state, then straight-line run
        cyc(0, 0, 0, 0, 1, 0, 0);
        cyc(1, 0, 0, 0, 1, 0, 0);
        cyc(1, 0, 0, 1, 0, 0, 0);
        cyc(1, 0, 1, 1, 0, 0, 1);
        cyc(1, 0, 2, 1, 0, 0, 2);
        cyc(1, 0, 3, 1, 0, 0, 3);
        cyc(1, 0, 3, 0, 1, 1, 4);
        cyc(1, 0, 3, 0, 1, 1, 4);
        cyc(0, 0, 3, 0, 1, 1, 4);
        cyc(0, 0, 0, 0, 1, 0, 4);

        // LW stretch, taken/not-taken branch, taken branch at last address
        prog[1] = LW;
        prog[2] = BR;
        prog[3] = BR;
        cyc(1, 0, 0, 0, 1, 0, 4);
        cyc(1, 0, 0, 1, 0, 0, 0);
        cyc(0, 0, 1, 0, 0, 0, 1);
        cyc(0, 0, 1, 0, 0, 0, 2);
        cyc(0, 0, 1, 1, 0, 0, 3);
        bt = 1'b1; tgt = 10'd0;
        cyc(0, 0, 2, 1, 0, 0, 4);
        bt = 1'b0;
        cyc(0, 0, 0, 1, 0, 0, 5);
        cyc(0, 0, 1, 0, 0, 0, 6);
        cyc(0, 0, 1, 0, 0, 0, 7);
        cyc(0, 0, 1, 1, 0, 0, 8);
        cyc(0, 0, 2, 1, 0, 0, 9);
        bt = 1'b1; tgt = 10'd3;
        cyc(0, 0, 3, 1, 0, 0, 10);
        bt = 1'b0;
        cyc(1, 0, 3, 1, 0, 0, 11);
        cyc(1, 0, 3, 0, 1, 1, 12);
        cyc(0, 0, 3, 0, 1, 1, 12);
        cyc(0, 0, 0, 0, 1, 0, 12);

        // reset while in LOAD_WAIT
        prog[3] = ADD;
        cyc(1, 0, 0, 0, 1, 0, 12);
        cyc(1, 0, 0, 1, 0, 0, 0);
        cyc(1, 0, 1, 0, 0, 0, 1);
        cyc(0, 1, 1, 0, 0, 0, 2);
        cyc(0, 0, 0, 0, 1, 0, 0);
        cyc(0, 0, 0, 0, 1, 0, 0);

        @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d expected vectors left, want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
